// File: rtl/lift.sv
// lift: single-car elevator controller for a building of up to 8 floors.
// Serves one hall call at a time. The car travels to the calling floor and
// opens its doors. It then samples the in-car destination button, carries the
// passenger there, opens the doors again and returns to idle. Nothing is
// queued: calls that arrive while the car is busy are dropped.
module lift #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] butt_el,
  input  logic       butt_up_down,
  input  logic [2:0] pass_f,
  output logic [2:0] elev_f_o,
  output logic       busy_o
);

  // The tick counter only ever counts 0 .. max(FLOOR_TICKS, DOOR_TICKS)-1.
  localparam int TICK_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TICK_W-1:0] FLOOR_LAST = TICK_W'(FLOOR_TICKS - 1);
  localparam logic [TICK_W-1:0] DOOR_LAST  = TICK_W'(DOOR_TICKS - 1);
  localparam logic [3:0]        FLOOR_CNT  = 4'(NUM_FLOORS);
  localparam logic [2:0]        TOP_FLOOR  = 3'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    MOVE_TO_PASS = 3'd1,
    DOOR_PICKUP  = 3'd2,
    MOVE_TO_DEST = 3'd3,
    DOOR_DROP    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        cur_floor, floor_nxt;
  logic [2:0]        target, target_nxt;
  logic [TICK_W-1:0] tick, tick_nxt;
  logic              busy, busy_nxt;

  logic [2:0]        floor_step;
  logic [2:0]        dest_floor;
  logic              call_ok;

  // A floor number is only meaningful if it names a real floor.
  function automatic logic floor_valid(input logic [2:0] f);
    return ({1'b0, f} < FLOOR_CNT);
  endfunction

  // Panel buttons beyond the top floor are treated as the top floor.
  function automatic logic [2:0] clamp_floor(input logic [2:0] f);
    return floor_valid(f) ? f : TOP_FLOOR;
  endfunction

  // One floor toward the target; holds position when already there, so the
  // car can never run past the target or off either end of the shaft.
  function automatic logic [2:0] step_toward(input logic [2:0] cur,
                                             input logic [2:0] tgt);
    logic [2:0] nxt;
    nxt = cur;
    if (tgt > cur) begin
      nxt = cur + 3'd1;
    end else if (tgt < cur) begin
      nxt = cur - 3'd1;
    end
    return nxt;
  endfunction

  assign floor_step = step_toward(cur_floor, target);
  assign dest_floor = clamp_floor(butt_el);
  assign call_ok    = butt_up_down && floor_valid(pass_f);

  // Next-state and next-register logic for the trip sequencer.
  always_comb begin
    state_nxt  = state;
    floor_nxt  = cur_floor;
    target_nxt = target;
    tick_nxt   = tick;
    busy_nxt   = busy;
    case (state)
      IDLE: begin
        if (call_ok) begin
          target_nxt = pass_f;
          tick_nxt   = '0;
          busy_nxt   = 1'b1;
          // A passenger already at the car skips straight to the doors.
          state_nxt  = (pass_f == cur_floor) ? DOOR_PICKUP : MOVE_TO_PASS;
        end
      end
      MOVE_TO_PASS, MOVE_TO_DEST: begin
        if (tick == FLOOR_LAST) begin
          floor_nxt = floor_step;
          tick_nxt  = '0;
          if (floor_step == target) begin
            state_nxt = (state == MOVE_TO_PASS) ? DOOR_PICKUP : DOOR_DROP;
          end
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      DOOR_PICKUP: begin
        if (tick == DOOR_LAST) begin
          // The only point at which the in-car panel is looked at.
          target_nxt = dest_floor;
          tick_nxt   = '0;
          state_nxt  = (dest_floor == cur_floor) ? DOOR_DROP : MOVE_TO_DEST;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      DOOR_DROP: begin
        if (tick == DOOR_LAST) begin
          tick_nxt  = '0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      default: begin
        tick_nxt  = '0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and position registers; reset abandons any trip and parks at floor 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      cur_floor <= '0;
      target    <= '0;
      tick      <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_floor <= floor_nxt;
      target    <= target_nxt;
      tick      <= tick_nxt;
      busy      <= busy_nxt;
    end
  end

  assign elev_f_o = cur_floor;
  assign busy_o   = busy;

endmodule

// File: tb/tb_lift.sv
// tb_lift: scoreboard bench for the lift controller. Stimulus queues the
// expected (cycle, floor, busy) events; per-car monitors compare each
// negedge and flag any output change that no queued event accounts for.
module tb_lift;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Car with default parameters
  logic       rst, call;
  logic [2:0] el, pf;
  logic [2:0] floor8;
  logic       busy8;

  // Car with only five floors
  logic       rst5, call5;
  logic [2:0] el5, pf5;
  logic [2:0] floor5;
  logic       busy5;

  lift dut (
    .clk          (clk),
    .rst_n        (rst),
    .butt_el      (el),
    .butt_up_down (call),
    .pass_f       (pf),
    .elev_f_o     (floor8),
    .busy_o       (busy8)
  );

  lift #(.NUM_FLOORS(5), .FLOOR_TICKS(4), .DOOR_TICKS(4)) dut5 (
    .clk          (clk),
    .rst_n        (rst5),
    .butt_el      (el5),
    .butt_up_down (call5),
    .pass_f       (pf5),
    .elev_f_o     (floor5),
    .busy_o       (busy5)
  );

  typedef struct {
    int         cyc;
    logic [2:0] f;
    logic       b;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8, e5;

  int checks = 0;
  int passed = 0;
  bit mon_en = 1'b0;

  logic [2:0] prev_f8 = '0, prev_f5 = '0;
  logic       prev_b8 = 1'b0, prev_b5 = 1'b0;

  task automatic expect8(input int c, input int f, input bit b);
    exp_t e;
    e.cyc = c; e.f = f[2:0]; e.b = b;
    q8.push_back(e);
  endtask

  task automatic expect5(input int c, input int f, input bit b);
    exp_t e;
    e.cyc = c; e.f = f[2:0]; e.b = b;
    q5.push_back(e);
  endtask

  task automatic score(input string nm, input exp_t e,
                       input logic [2:0] f, input logic b);
    checks++;
    if (f === e.f && b === e.b) begin
      passed++;
    end else begin
      $display("FAIL %s cycle %0d: got floor=%0d busy=%0b, required floor=%0d busy=%0b",
               nm, e.cyc, f, b, e.f, e.b);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor for the 8-floor car
  always @(negedge clk) begin
    if (mon_en) begin
      if (q8.size() > 0 && q8[0].cyc == cyc) begin
        e8 = q8.pop_front();
        score("car8", e8, floor8, busy8);
      end else if (floor8 !== prev_f8 || busy8 !== prev_b8) begin
        checks++;
        $display("FAIL car8 unexpected change at cycle %0d: got floor=%0d busy=%0b, required floor=%0d busy=%0b",
                 cyc, floor8, busy8, prev_f8, prev_b8);
      end
      while (q8.size() > 0 && q8[0].cyc < cyc) begin
        e8 = q8.pop_front();
        checks++;
        $display("FAIL car8 event for cycle %0d never matched: got floor=%0d busy=%0b, required floor=%0d busy=%0b",
                 e8.cyc, floor8, busy8, e8.f, e8.b);
      end
      prev_f8 = floor8;
      prev_b8 = busy8;
    end
  end

  // Monitor for the 5-floor car
  always @(negedge clk) begin
    if (mon_en) begin
      if (q5.size() > 0 && q5[0].cyc == cyc) begin
        e5 = q5.pop_front();
        score("car5", e5, floor5, busy5);
      end else if (floor5 !== prev_f5 || busy5 !== prev_b5) begin
        checks++;
        $display("FAIL car5 unexpected change at cycle %0d: got floor=%0d busy=%0b, required floor=%0d busy=%0b",
                 cyc, floor5, busy5, prev_f5, prev_b5);
      end
      while (q5.size() > 0 && q5[0].cyc < cyc) begin
        e5 = q5.pop_front();
        checks++;
        $display("FAIL car5 event for cycle %0d never matched: got floor=%0d busy=%0b, required floor=%0d busy=%0b",
                 e5.cyc, floor5, busy5, e5.f, e5.b);
      end
      prev_f5 = floor5;
      prev_b5 = busy5;
    end
  end

  int e, e2, e3, e4, c5, e5c;

  initial begin
    // Reset for two edges with random inputs on both cars
    rst   = 1'b1;  rst5  = 1'b1;
    call  = 1'($urandom); pf  = 3'($urandom); el  = 3'($urandom);
    call5 = 1'($urandom); pf5 = 3'($urandom); el5 = 3'($urandom);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    expect8(2, 0, 0);
    expect5(2, 0, 0);
    @(negedge clk);
    rst  = 1'b0; call  = 1'b0; pf  = '0; el  = '0;
    rst5 = 1'b0; call5 = 1'b0; pf5 = '0; el5 = '0;

    // Full upward trip 0 -> 3 -> 7, call pulsed for one cycle
    wait_cyc(4);
    call = 1'b1; pf = 3'd3; el = 3'd7;
    e = cyc + 1;
    expect8(e,      0, 1);
    expect8(e + 4,  1, 1);
    expect8(e + 8,  2, 1);
    expect8(e + 12, 3, 1);
    expect8(e + 20, 4, 1);
    expect8(e + 24, 5, 1);
    expect8(e + 28, 6, 1);
    expect8(e + 32, 7, 1);
    expect8(e + 36, 7, 0);
    @(negedge clk);
    call = 1'b0;

    // Busy lockout: a hall call at floor 6 and panel changes away from the sample
    wait_cyc(e + 4);
    call = 1'b1; pf = 3'd6;
    wait_cyc(e + 8);
    call = 1'b0;
    wait_cyc(e + 18);
    el = 3'd1;
    wait_cyc(e + 22);
    el = 3'd2;

    // Held call: re-accepted one edge after idle, 7 -> 2 -> 5
    wait_cyc(e + 34);
    call = 1'b1; pf = 3'd2; el = 3'd5;
    e2 = e + 37;
    expect8(e2,      7, 1);
    expect8(e2 + 4,  6, 1);
    expect8(e2 + 8,  5, 1);
    expect8(e2 + 12, 4, 1);
    expect8(e2 + 16, 3, 1);
    expect8(e2 + 20, 2, 1);
    expect8(e2 + 28, 3, 1);
    expect8(e2 + 32, 4, 1);
    expect8(e2 + 36, 5, 1);
    expect8(e2 + 40, 5, 0);
    wait_cyc(e2 + 1);
    call = 1'b0;

    // Mid-trip reset while descending through floor 3
    wait_cyc(e2 + 42);
    call = 1'b1; pf = 3'd0; el = 3'd0;
    e3 = cyc + 1;
    expect8(e3,      5, 1);
    expect8(e3 + 4,  4, 1);
    expect8(e3 + 8,  3, 1);
    expect8(e3 + 10, 0, 0);
    @(negedge clk);
    call = 1'b0;
    wait_cyc(e3 + 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Same-floor call: doors only, busy for two door periods
    wait_cyc(e3 + 12);
    call = 1'b1; pf = 3'd0; el = 3'd0;
    e4 = cyc + 1;
    expect8(e4,     0, 1);
    expect8(e4 + 8, 0, 0);
    @(negedge clk);
    call = 1'b0;

    // Five-floor car: calls from floors 6 and 5 ignored, panel 7 clamps to 4
    wait_cyc(e4 + 12);
    c5 = cyc;
    call5 = 1'b1; pf5 = 3'd6;
    @(negedge clk);
    pf5 = 3'd5;
    expect5(c5 + 2, 0, 0);
    @(negedge clk);
    pf5 = 3'd1; el5 = 3'd7;
    e5c = cyc + 1;
    expect5(e5c,      0, 1);
    expect5(e5c + 4,  1, 1);
    expect5(e5c + 12, 2, 1);
    expect5(e5c + 16, 3, 1);
    expect5(e5c + 20, 4, 1);
    expect5(e5c + 24, 4, 0);
    @(negedge clk);
    call5 = 1'b0;

    // Drain the scoreboards within a bounded number of cycles
    for (int i = 0; i < 300 && (q8.size() > 0 || q5.size() > 0); i++) @(negedge clk);
    repeat (10) @(negedge clk);
    while (q8.size() > 0) begin
      e8 = q8.pop_front();
      checks++;
      $display("FAIL car8 event for cycle %0d still pending: required floor=%0d busy=%0b",
               e8.cyc, e8.f, e8.b);
    end
    while (q5.size() > 0) begin
      e5 = q5.pop_front();
      checks++;
      $display("FAIL car5 event for cycle %0d still pending: required floor=%0d busy=%0b",
               e5.cyc, e5.f, e5.b);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
